// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the ALU execution unit.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AINV = 4'b0110;
  localparam logic [3:0] OP_INC  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops; MUL is flagged as multi-cycle and
// left to the iterative datapath in the wrapper.
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             illegal_o,
  output logic             multi_o
);

  logic [WIDTH:0] sum, diff, inc;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign inc  = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result_o  = '0;
    carry_o   = 1'b0;
    illegal_o = 1'b0;
    multi_o   = 1'b0;
    case (sel_i)
      OP_ADD:  begin result_o = sum[WIDTH-1:0];  carry_o = sum[WIDTH];  end
      OP_SUB:  begin result_o = diff[WIDTH-1:0]; carry_o = diff[WIDTH]; end
      OP_AINV: result_o = ~a_i;
      OP_INC:  begin result_o = inc[WIDTH-1:0];  carry_o = inc[WIDTH];  end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_MUL:  multi_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked one-in-flight ALU wrapper: registered responses, single-cycle
// ops via alu_core, MUL via a WIDTH-cycle shift-add loop.
import alu_pkg::*;

module alu_exec_unit #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_sel,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, carry_q, carry_d, illegal_q, illegal_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [WIDTH-1:0] core_res;
  logic             core_carry, core_illegal, core_multi;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i       (req_a),
    .b_i       (req_b),
    .sel_i     (req_sel),
    .result_o  (core_res),
    .carry_o   (core_carry),
    .illegal_o (core_illegal),
    .multi_o   (core_multi)
  );

  // DONE frees the slot in the same cycle the response is taken.
  assign req_ready = (state_q == S_IDLE) || (state_q == S_DONE && rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;
    tag_d     = tag_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          tag_d = req_tag;
          if (core_multi) begin
            state_d  = S_MUL;
            acc_d    = '0;
            cnt_d    = '0;
            mcand_d  = req_a;
            mplier_d = req_b;
          end else begin
            state_d   = S_DONE;
            res_d     = core_res;
            zero_d    = (core_res == '0);
            carry_d   = core_carry;
            illegal_d = core_illegal;
          end
        end else if (state_q == S_DONE && rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_DONE;
          res_d     = acc_d;
          zero_d    = (acc_d == '0);
          carry_d   = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
      tag_q     <= tag_d;
    end
  end

  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_carry   = carry_q;
  assign rsp_illegal = illegal_q;
  assign rsp_tag     = tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic [3:0]       req_sel;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_carry, rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sel     (req_sel),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_carry   (rsp_carry),
    .rsp_illegal (rsp_illegal),
    .rsp_tag     (rsp_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] sel, input logic [3:0] tag);
    int w = 0;
    while (!req_ready && w < 100) begin tick(); w++; end
    chk("send_ready", req_ready, 1);
    req_a = a; req_b = b; req_sel = sel; req_tag = tag; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("retire_valid", rsp_valid, 0);
  endtask

  task automatic expect_rsp(input string t, input logic [31:0] res, input logic z,
                            input logic c, input logic ill, input logic [3:0] tag);
    chk({t, "_valid"}, rsp_valid, 1);
    chk({t, "_res"}, rsp_result, res);
    chk({t, "_flags"}, {rsp_zero, rsp_carry, rsp_illegal}, {z, c, ill});
    chk({t, "_tag"}, rsp_tag, tag);
  endtask

  task automatic op1(input string t, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] sel, input logic [3:0] tag, input logic [31:0] res,
                     input logic z, input logic c, input logic ill);
    send(a, b, sel, tag);
    expect_rsp(t, res, z, c, ill, tag);
    retire();
  endtask

  task automatic mul(input string t, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] tag, input logic [31:0] res, input logic z);
    int lat = 0;
    int lows = 0;
    send(a, b, 4'b1100, tag);
    while (!rsp_valid && lat < 100) begin
      if (!req_ready) lows++;
      tick();
      lat++;
    end
    chk({t, "_lat"}, lat, 32);
    chk({t, "_ready_low"}, lows, 32);
    expect_rsp(t, res, z, 0, 0, tag);
    retire();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_sel = '0; req_tag = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out", {rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal, rsp_tag}, 0);
    chk("rst_ready", req_ready, 1);

    op1("and",  32'hAF554D4E, 32'h87AA9777, 4'b1001, 4'd3, 32'h87000546, 0, 0, 0);
    op1("add",  32'hAF554D4E, 32'h87AA9777, 4'b0100, 4'd4, 32'h36FFE4C5, 0, 1, 0);
    op1("sub0", 32'h87AA9777, 32'h87AA9777, 4'b0101, 4'd5, 32'h00000000, 1, 0, 0);
    op1("subb", 32'h00000005, 32'h00000007, 4'b0101, 4'd6, 32'hFFFFFFFE, 0, 1, 0);
    op1("inc",  32'hFFFFFFFF, 32'h0,        4'b0111, 4'd8, 32'h00000000, 1, 1, 0);
    op1("inc2", 32'h0000000F, 32'h0,        4'b0111, 4'd9, 32'h00000010, 0, 0, 0);
    op1("ainv", 32'h00000000, 32'h12345678, 4'b0110, 4'd1, 32'hFFFFFFFF, 0, 0, 0);
    op1("or",   32'h12340000, 32'h00005678, 4'b1010, 4'd2, 32'h12345678, 0, 0, 0);
    op1("ill0", 32'h12345678, 32'h9ABCDEF0, 4'b0000, 4'd10, 32'h0, 1, 0, 1);
    op1("ill15",32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111, 4'd11, 32'h0, 1, 0, 1);

    mul("mul35", 32'h3, 32'h5, 4'd12, 32'h0000000F, 0);
    mul("mulov", 32'h00010000, 32'h00010000, 4'd13, 32'h0, 1);
    mul("mulff", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, 32'h00000001, 0);

    // Backpressure, then retire and accept on the same edge.
    send(32'h0000FFFF, 32'h0F0F0F0F, 4'b1001, 4'd6);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_rsp("bp", 32'h00000F0F, 0, 0, 0, 4'd6);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_a = 32'hF0F0F0F0; req_b = 32'h0FF00FF0; req_sel = 4'b1011; req_tag = 4'd7;
    req_valid = 1'b1;
    #1;
    chk("b2b_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    expect_rsp("b2b", 32'hFF00FF00, 0, 0, 0, 4'd7);
    retire();

    // Reset in the middle of a multiply discards it.
    send(32'h3, 32'h5, 4'b1100, 4'd15);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out", {rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal, rsp_tag}, 0);
    chk("mrst_ready", req_ready, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin tick(); if (rsp_valid) seen++; end
      chk("mrst_norsp", seen, 0);
    end
    op1("post", 32'h1, 32'h1, 4'b0100, 4'd2, 32'h2, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Handshaked, registered execution wrapper that services ALU operation requests from a sequencer or bench initiator and returns tagged results with flags.
- Holds one operation in flight.
- Single-cycle ops go through a combinational core; MUL runs an iterative shift-add over WIDTH cycles.
- Sits between the instruction/operand sequencer and the writeback stage.

Parameters:
WIDTH, 32, operand/result width in bits.
TAG_W, 4, width of the opaque request tag echoed on the response.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request this cycle.
req_a  in  WIDTH  operand A.
req_b  in  WIDTH  operand B.
req_sel  in  4  opcode.
req_tag  in  TAG_W  request tag.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_result  out  WIDTH  result.
rsp_zero  out  1  result == 0.
rsp_carry  out  1  carry/borrow flag.
rsp_illegal  out  1  opcode was not recognised.
rsp_tag  out  TAG_W  echoed req_tag.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Opcodes:
  - 0100 ADD: A+B; carry = bit WIDTH of the sum.
  - 0101 SUB: A-B; carry = borrow (1 when A<B unsigned).
  - 0110 AINV: ~A; carry 0.
  - 0111 INC: A+1; carry 1 only when A is all ones.
  - 1001 AND, 1010 OR, 1011 XOR: bitwise; carry 0.
  - 1100 MUL: low WIDTH bits of A*B, unsigned; carry 0.
  - Any other opcode: result 0, zero 1, carry 0, illegal 1.
- Arithmetic wraps modulo 2^WIDTH.
- A request is accepted on an edge where req_valid and req_ready are both 1. a, b, sel and tag are captured at that edge.
- FSM states: IDLE, MUL, DONE.
  - IDLE: req_ready=1.
    - On accept of a non-MUL op: register the core result and flags, go to DONE. rsp_valid is 1 in the cycle after the accept edge (latency 1).
    - On accept of MUL: go to MUL with accumulator=0 and count=0.
  - MUL: req_ready=0, rsp_valid=0.
    - Each edge: if multiplier bit0 is 1, accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
    - After WIDTH edges, go to DONE. rsp_valid is 1 in the cycle after the WIDTH-th MUL edge (latency WIDTH+1 edges from accept).
  - DONE: rsp_valid=1; all rsp_* stable until handshake.
    - rsp_ready=0: stay; req_ready=0.
    - rsp_ready=1: response completes. req_ready=1 in the same cycle, so back-to-back is allowed. If req_valid is also 1, the new request is accepted on that edge and the next state follows the IDLE rules. Otherwise go to IDLE.
- rsp_zero is computed from the final registered result.
- Outputs change only on edges; there are no combinational paths from req_* to rsp_*.
- req_ready depends combinationally on state and rsp_ready only.
- Reset (any state, including mid-MUL or while DONE is waiting): next state IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_carry=0, rsp_illegal=0, rsp_tag=0, accumulator and count cleared. Any in-flight op is discarded with no response. req_ready=1 in the first cycle after reset.
- req_valid while req_ready=0 is ignored; the initiator must hold it.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD, OP_SUB, OP_AINV, OP_INC, OP_AND, OP_OR, OP_XOR, OP_MUL.
  - State encoding constants S_IDLE, S_MUL, S_DONE.
  - Default WIDTH.
- One sub-module, alu_core: purely combinational single-cycle ops. Outputs result, carry and illegal; MUL is reported as not-single-cycle.
- The FSM, MUL datapath and output registers live in alu_exec_unit.

Test Plan:
- AND: A=AF554D4E, B=87AA9777, sel=1001, tag=3, rsp_ready=1 -> one cycle later result=87000546, zero=0, carry=0, tag=3.
- ADD with carry: same operands, sel=0100 -> result=36FFE4C5, carry=1. SUB: A=B=87AA9777 -> result=0, zero=1, carry=0. INC: A=FFFFFFFF -> result=0, zero=1, carry=1.
- MUL: A=3, B=5 -> req_ready low for 32 cycles, rsp_valid on the cycle after the 32nd MUL edge, result=0000000F. MUL: A=B=00010000 -> result=0, zero=1.
- Backpressure and back-to-back: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0. Then raise rsp_ready with req_valid=1 (XOR, tag=7) -> old response retires and the new one is accepted on the same edge. The next response is A^B with tag 7.
- Illegal opcode: sel=0000 -> result=0, zero=1, illegal=1, latency 1.
- Reset mid-MUL: assert rst at MUL cycle 10 -> no response; all outputs 0 and req_ready=1 after release. A following ADD 1+1 returns 2.
